tdc_thermo_capture: RTL and testbench

//  Downstream stage of the tapped carry-chain delay line. Samples the raw tap

---
 rtl/tdc_thermo_capture_pkg.sv | 33 +++
 rtl/tdc_thermo_capture_if.sv | 17 +
 rtl/tdc_thermo_capture_popcount.sv | 21 ++
 rtl/tdc_thermo_capture.sv | 119 +++++++++++
 tb/tb_tdc_thermo_capture.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_thermo_capture_pkg.sv
// Purpose: shared widths and ts_word field offsets for the TDC capture stage
//          and the readout formatter that unpacks its words.
// Ports:   none (package).
package tdc_pkg;

    // Fine-count width: must hold 0..taps inclusive.
    function automatic int unsigned fine_w_calc(input int unsigned taps);
        return $clog2(taps + 1);
    endfunction

    // Timestamp word width: {ovf, coarse, fine}.
    function automatic int unsigned ts_w_calc(input int unsigned taps, input int unsigned coarse_w);
        return 1 + coarse_w + fine_w_calc(taps);
    endfunction

    // Field offsets inside a timestamp word.
    localparam int unsigned FINE_LSB = 0;

    function automatic int unsigned coarse_lsb_calc(input int unsigned taps);
        return fine_w_calc(taps);
    endfunction

    function automatic int unsigned ovf_bit_calc(input int unsigned taps, input int unsigned coarse_w);
        return coarse_w + fine_w_calc(taps);
    endfunction

    // Offsets for the default build (64 taps, 16-bit coarse counter).
    localparam int unsigned DEF_TAPS     = 64;
    localparam int unsigned DEF_COARSE_W = 16;
    localparam int unsigned COARSE_LSB   = coarse_lsb_calc(DEF_TAPS);
    localparam int unsigned OVF_BIT      = ovf_bit_calc(DEF_TAPS, DEF_COARSE_W);

endpackage

// File: rtl/tdc_thermo_capture_if.sv
// Purpose: timestamp output stream of the TDC capture stage.
// Signals: ts_valid/ts_ready handshake, ts_data word, drop_count status.
//          master = capture stage, slave = readout consumer.
interface tdc_thermo_capture_if
    import tdc_pkg::*;
#(
    parameter int unsigned TS_W   = ts_w_calc(DEF_TAPS, DEF_COARSE_W),
    parameter int unsigned DROP_W = 8
);
    logic              ts_valid;
    logic              ts_ready;
    logic [TS_W-1:0]   ts_data;
    logic [DROP_W-1:0] drop_count;

    modport master (output ts_valid, output ts_data, output drop_count, input ts_ready);
    modport slave  (input ts_valid, input ts_data, input drop_count, output ts_ready);
endinterface

// File: rtl/tdc_thermo_capture_popcount.sv
// Purpose: combinational ones counter over a thermometer sample; counting
//          ones rather than locating the edge makes it tolerant of bubbles.
// Ports:   bits_i  (N)  sampled taps
//          count_o (CW) number of ones, 0..N
module thermo_popcount #(
    parameter int unsigned N = 64,
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bits_i,
    output logic [CW-1:0] count_o
);

    // Written as a sum; synthesis balances it into an adder tree.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/tdc_thermo_capture.sv
// Purpose: double-registers the delay-line taps, detects rising hits, encodes
//          the fine count, tags it with the coarse counter and queues
//          {ovf, coarse, fine} words in a first-word-fall-through FIFO.
// Ports:   clk, rst      clock, synchronous active-high reset
//          enable_i      accept hits when high
//          taps_i        raw asynchronous delay-line taps
//          ts_if.master  ts_valid/ts_ready/ts_data stream and drop_count
module tdc_thermo_capture
    import tdc_pkg::*;
#(
    parameter int unsigned TAPS       = 64,
    parameter int unsigned COARSE_W   = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DROP_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_i,
    input  logic [TAPS-1:0] taps_i,
    tdc_thermo_capture_if.master ts_if
);

    localparam int unsigned FINE_W = fine_w_calc(TAPS);
    localparam int unsigned TS_W   = ts_w_calc(TAPS, COARSE_W);
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    (* keep *) logic [TAPS-1:0] s1_q;
    logic [TAPS-1:0]     s2_q;
    logic                v1_q, v2_q;
    logic                prev_tap0_q;
    logic [COARSE_W-1:0] coarse_q, cap_coarse1_q, cap_coarse2_q, cap_coarse3_q;
    logic [FINE_W-1:0]   fine_c, fine_q;
    logic                ovf_q, hit_q, hit_c;

    logic [TS_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_c;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                empty_c, full_c, pop_c, push_c, drop_c;
    logic [TS_W-1:0]     word_c;

    thermo_popcount #(.N(TAPS)) u_popcount (
        .bits_i  (s2_q),
        .count_o (fine_c)
    );

    assign hit_c = enable_i & s2_q[0] & ~prev_tap0_q;

    // Sampling pipeline, coarse counter and registered decode.
    // v1/v2 mark s1/s2 as holding real samples; until s2 is real, prev_tap0
    // is held high so a level already high at reset release is not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            prev_tap0_q   <= 1'b1;
            coarse_q      <= '0;
            cap_coarse1_q <= '0;
            cap_coarse2_q <= '0;
            cap_coarse3_q <= '0;
            fine_q        <= '0;
            ovf_q         <= 1'b0;
            hit_q         <= 1'b0;
        end else begin
            s1_q          <= taps_i;
            s2_q          <= s1_q;
            v1_q          <= 1'b1;
            v2_q          <= v1_q;
            prev_tap0_q   <= v2_q ? s2_q[0] : 1'b1;
            coarse_q      <= coarse_q + COARSE_W'(1);
            cap_coarse1_q <= coarse_q;
            cap_coarse2_q <= cap_coarse1_q;
            cap_coarse3_q <= cap_coarse2_q;
            fine_q        <= fine_c;
            ovf_q         <= &s2_q;
            hit_q         <= hit_c;
        end
    end

    // Queue control: a full queue still accepts a push when it pops that cycle.
    always_comb begin
        word_c   = {ovf_q, cap_coarse3_q, fine_q};
        count_c  = wr_ptr_q - rd_ptr_q;
        empty_c  = (wr_ptr_q == rd_ptr_q);
        full_c   = (count_c == PTR_W'(FIFO_DEPTH));
        pop_c    = ~empty_c & ts_if.ts_ready;
        push_c   = hit_q & (~full_c | pop_c);
        drop_c   = hit_q & full_c & ~pop_c;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        drop_d   = (drop_c && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
    end

    // Queue storage is cleared on reset so ts_data reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
            if (push_c) begin
                mem_q[wr_ptr_q[ADDR_W-1:0]] <= word_c;
            end
        end
    end

    assign ts_if.ts_valid   = ~empty_c;
    assign ts_if.ts_data    = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign ts_if.drop_count = drop_q;

endmodule

// File: tb/tb_tdc_thermo_capture.sv
// Purpose: self-checking bench for tdc_thermo_capture (8 taps, 8-bit coarse,
//          4-entry queue); expected words are queued as hits are driven and
//          compared when the consumer accepts them.
module tb_tdc_thermo_capture;

    localparam int unsigned TAPS       = 8;
    localparam int unsigned COARSE_W   = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned DROP_W     = 8;
    localparam int unsigned TS_W       = 1 + COARSE_W + 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b1;
    logic [TAPS-1:0] taps = '0;

    tdc_thermo_capture_if #(.TS_W(TS_W), .DROP_W(DROP_W)) ts_if ();

    tdc_thermo_capture #(
        .TAPS       (TAPS),
        .COARSE_W   (COARSE_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DROP_W     (DROP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable),
        .taps_i   (taps),
        .ts_if    (ts_if.master)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    int              exp_drop = 0;
    int unsigned     cyc = 0;
    logic [TS_W-1:0] sb [$];

    // Edges since reset release: equals the coarse value sampled at the next edge.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [TS_W-1:0] mk_word(input logic [TAPS-1:0] p, input int unsigned c);
        logic [3:0] n;
        logic [7:0] cw;
        n = '0;
        for (int i = 0; i < TAPS; i++) n = n + 4'(p[i]);
        cw = 8'(c);
        return {&p, cw, n};
    endfunction

    // Consumer side: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && ts_if.ts_valid && ts_if.ts_ready) begin
            if (sb.size() == 0) begin
                check("extra_word", 32'(ts_if.ts_data), 32'hFFFF_FFFF);
            end else begin
                check("ts_data", 32'(ts_if.ts_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int unsigned target);
        for (int i = 0; i < 600; i++) begin
            if ((cyc % 256) == target) break;
            step(1);
        end
    endtask

    task automatic hit(input logic [TAPS-1:0] p, input bit dropped);
        taps = p;
        if (dropped) exp_drop++;
        else sb.push_back(mk_word(p, cyc));
        step(1);
        taps = '0;
        step(1);
    endtask

    task automatic reset_checks();
        check("rst_valid", 32'(ts_if.ts_valid), 0);
        check("rst_data", 32'(ts_if.ts_data), 0);
        check("rst_drop", 32'(ts_if.drop_count), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        reset_checks();
        sb.delete();
        exp_drop = 0;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int n);
        ts_if.ts_ready = 1'b1;
        step(n);
        check({tag, "_sb_empty"}, 32'(sb.size()), 0);
        check({tag, "_valid"}, 32'(ts_if.ts_valid), 0);
    endtask

    initial begin
        logic [TS_W-1:0] w1;
        ts_if.ts_ready = 1'b1;
        do_reset();

        // Single hit, latency and exact word.
        step(10);
        wait_cyc(20);
        taps = 8'b0000_0111;
        sb.push_back(mk_word(taps, cyc));
        step(3);
        check("lat_n2_valid", 32'(ts_if.ts_valid), 0);
        step(1);
        w1 = {1'b0, 8'd20, 4'd3};
        check("lat_n3_valid", 32'(ts_if.ts_valid), 1);
        check("first_word", 32'(ts_if.ts_data), 32'(w1));
        step(6);
        check("t1_one_word", 32'(sb.size()), 0);
        check("t1_valid", 32'(ts_if.ts_valid), 0);
        taps = '0;
        step(4);

        // Bubble at coarse 5.
        do_reset();
        wait_cyc(5);
        hit(8'b0101_1111, 1'b0);
        drain("t2", 5);

        // Overflow, then held high and falling edge produce nothing.
        taps = 8'hFF;
        sb.push_back(mk_word(taps, cyc));
        step(12);
        check("t3_sb_empty", 32'(sb.size()), 0);
        check("t3_held_valid", 32'(ts_if.ts_valid), 0);
        taps = '0;
        step(6);
        check("t3_fall_valid", 32'(ts_if.ts_valid), 0);

        // Six hits into a stalled 4-entry queue.
        ts_if.ts_ready = 1'b0;
        hit(8'h01, 1'b0);
        hit(8'h03, 1'b0);
        hit(8'h07, 1'b0);
        hit(8'h0F, 1'b0);
        hit(8'h1F, 1'b1);
        hit(8'h3F, 1'b1);
        step(4);
        check("t4_drop", 32'(ts_if.drop_count), 32'(exp_drop));
        check("t4_head_held", 32'(ts_if.ts_data), 32'(sb[0]));
        check("t4_valid", 32'(ts_if.ts_valid), 1);
        step(3);
        check("t4_head_held2", 32'(ts_if.ts_data), 32'(sb[0]));
        drain("t4", 10);

        // Full queue with a pop in the push cycle: no drop.
        ts_if.ts_ready = 1'b0;
        hit(8'h01, 1'b0);
        hit(8'h03, 1'b0);
        hit(8'h07, 1'b0);
        hit(8'h0F, 1'b0);
        taps = 8'h1F;
        sb.push_back(mk_word(taps, cyc));
        step(1);
        taps = '0;
        step(2);
        ts_if.ts_ready = 1'b1;
        step(1);
        ts_if.ts_ready = 1'b0;
        step(2);
        check("t5_drop", 32'(ts_if.drop_count), 32'(exp_drop));
        check("t5_sb_size", 32'(sb.size()), 4);
        drain("t5", 12);

        // Coarse wrap between two hits.
        wait_cyc(254);
        hit(8'h03, 1'b0);
        hit(8'h07, 1'b0);
        drain("wrap", 6);

        // Disabled: hits ignored.
        enable = 1'b0;
        taps = 8'h07;
        step(1);
        taps = '0;
        step(6);
        check("dis_valid", 32'(ts_if.ts_valid), 0);
        enable = 1'b1;

        // Level held high through reset release.
        taps = 8'h01;
        do_reset();
        step(10);
        check("t6_held_valid", 32'(ts_if.ts_valid), 0);
        taps = '0;
        step(3);

        // Reset with two queued and one in flight.
        ts_if.ts_ready = 1'b0;
        hit(8'h01, 1'b0);
        hit(8'h03, 1'b0);
        step(2);
        check("t6_queued", 32'(ts_if.ts_valid), 1);
        taps = 8'h07;
        step(1);
        taps = '0;
        do_reset();
        ts_if.ts_ready = 1'b1;
        step(10);
        check("t6_post_valid", 32'(ts_if.ts_valid), 0);
        check("t6_post_drop", 32'(ts_if.drop_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
